// File: rtl/seq_detect_scheduler_if.sv
// Requester / result bus for the shared sequence detector.
// The master modport is the producer side, the slave modport is the detector.
interface seq_detect_scheduler_if #(
   parameter int NREQ   = 4,
   parameter int WORD_W = 8,
   parameter int PAT_W  = 4
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW  = $clog2(WORD_W + 1);

   logic [NREQ-1:0]        req;
   logic [NREQ*WORD_W-1:0] word_in;
   logic [NREQ-1:0]        ack;
   logic                   busy;
   logic                   result_valid;
   logic [IDW-1:0]         result_id;
   logic                   result_hit;
   logic [CW-1:0]          result_count;

   modport master (
      output req, word_in,
      input  ack, busy, result_valid, result_id, result_hit, result_count
   );

   modport slave (
      input  req, word_in,
      output ack, busy, result_valid, result_id, result_hit, result_count
   );
endinterface

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler feeding one serial MSB-first bit-pattern matcher.
//  state  | meaning
//  IDLE   | waiting for a request; ack is combinational from the round-robin pick
//  SHIFT  | WORD_W cycles, one word bit per cycle into the matcher
//  REPORT | result_valid pulse, advance round-robin pointer past the granted requester
module seq_detect_scheduler #(
   parameter int NREQ   = 4,
   parameter int WORD_W = 8,
   parameter int PAT_W  = 4,
   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int LW    = $clog2(PAT_W + 1),
   localparam int CW    = $clog2(WORD_W + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   seq_detect_scheduler_if.slave bus,
   input  logic [PAT_W-1:0]     cfg_pattern,
   input  logic [LW-1:0]        cfg_len,
   input  logic                 cfg_overlap
);

   typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

   state_t            state;
   logic [IDW-1:0]    rr_ptr;
   logic [IDW-1:0]    gnt_id;
   logic [WORD_W-1:0] word_r;
   logic [PAT_W-1:0]  pat_r;
   logic [LW-1:0]     len_r;
   logic              ovl_r;
   logic [PAT_W-1:0]  hist;
   logic [LW-1:0]     seen;
   logic [CW-1:0]     bit_cnt;
   logic [CW-1:0]     match_cnt;

   logic              found;
   logic [IDW-1:0]    gnt_k;
   logic [LW-1:0]     len_clamped;
   logic              bit_in;
   logic [PAT_W-1:0]  hist_n;
   logic [LW-1:0]     seen_n;
   logic [PAT_W-1:0]  len_mask;
   logic              match;

   always_comb begin
      found = 1'b0;
      gnt_k = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && bus.req[(int'(rr_ptr) + i) % NREQ]) begin
            found = 1'b1;
            gnt_k = IDW'((int'(rr_ptr) + i) % NREQ);
         end
      end
   end

   assign bus.ack = (state == IDLE && found) ? (NREQ'(1) << gnt_k) : '0;

   assign len_clamped = (cfg_len > LW'(PAT_W)) ? LW'(PAT_W) : cfg_len;

   always_comb begin
      bit_in = word_r[WORD_W-1];
      hist_n = {hist[PAT_W-2:0], bit_in};
      seen_n = (seen >= LW'(PAT_W)) ? LW'(PAT_W) : seen + LW'(1);
      len_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         len_mask[i] = (LW'(i) < len_r);
      end
      match = (len_r != '0) && (seen_n >= len_r) &&
              (((hist_n ^ pat_r) & len_mask) == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         rr_ptr           <= '0;
         gnt_id           <= '0;
         word_r           <= '0;
         pat_r            <= '0;
         len_r            <= '0;
         ovl_r            <= 1'b0;
         hist             <= '0;
         seen             <= '0;
         bit_cnt          <= '0;
         match_cnt        <= '0;
         bus.busy         <= 1'b0;
         bus.result_valid <= 1'b0;
         bus.result_id    <= '0;
         bus.result_hit   <= 1'b0;
         bus.result_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  word_r    <= bus.word_in[int'(gnt_k)*WORD_W +: WORD_W];
                  gnt_id    <= gnt_k;
                  pat_r     <= cfg_pattern;
                  len_r     <= len_clamped;
                  ovl_r     <= cfg_overlap;
                  hist      <= '0;
                  seen      <= '0;
                  bit_cnt   <= '0;
                  match_cnt <= '0;
                  bus.busy  <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               word_r  <= word_r << 1;
               bit_cnt <= bit_cnt + CW'(1);
               if (match && !ovl_r) begin
                  hist <= '0;
                  seen <= '0;
               end else begin
                  hist <= hist_n;
                  seen <= seen_n;
               end
               if (match) match_cnt <= match_cnt + CW'(1);
               // Result registers load on the last bit so the pulse lines up with REPORT.
               if (bit_cnt == CW'(WORD_W - 1)) begin
                  bus.result_valid <= 1'b1;
                  bus.result_id    <= gnt_id;
                  bus.result_count <= match_cnt + CW'(match);
                  bus.result_hit   <= (match_cnt != '0) || match;
                  state            <= REPORT;
               end
            end
            REPORT: begin
               bus.result_valid <= 1'b0;
               bus.busy         <= 1'b0;
               rr_ptr           <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench: vector table of single-requester words plus round-robin and reset-abort sequences.
module tb_seq_detect_scheduler;
   localparam int NREQ   = 4;
   localparam int WORD_W = 8;
   localparam int PAT_W  = 4;
   localparam int LW     = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cfg_pattern;
   logic [2:0] cfg_len;
   logic       cfg_overlap;
   int         cyc = 0;
   int         tests = 0;
   int         fails = 0;

   seq_detect_scheduler_if #(.NREQ(NREQ), .WORD_W(WORD_W), .PAT_W(PAT_W)) bus ();

   seq_detect_scheduler #(.NREQ(NREQ), .WORD_W(WORD_W), .PAT_W(PAT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         rq;
      logic [7:0] word;
      logic [3:0] pat;
      logic [2:0] len;
      logic       ovl;
      int         count;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic run_word(input vec_t v, input string tag);
      int n;
      logic [31:0] ack_exp;
      ack_exp = 32'd1 << v.rq;
      bus.word_in = {4{~v.word}};
      bus.word_in[v.rq*WORD_W +: WORD_W] = v.word;
      bus.req = '0;
      bus.req[v.rq] = 1'b1;
      cfg_pattern = v.pat;
      cfg_len = v.len;
      cfg_overlap = v.ovl;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.ack == '0 && n < 30);
      check({tag, " ack"}, int'(bus.ack), int'(ack_exp));
      @(posedge clk); #1;
      // Disturb inputs after the grant; the word in flight must not notice.
      bus.req = '0;
      bus.word_in = '0;
      cfg_pattern = ~v.pat;
      cfg_len = 3'd0;
      cfg_overlap = ~v.ovl;
      @(negedge clk);
      check({tag, " busy"}, int'(bus.busy), 1);
      n = 1;
      while (!bus.result_valid && n < 30) begin @(negedge clk); n++; end
      check({tag, " latency"}, n, WORD_W + 1);
      check({tag, " id"}, int'(bus.result_id), v.rq);
      check({tag, " count"}, int'(bus.result_count), v.count);
      check({tag, " hit"}, int'(bus.result_hit), (v.count != 0) ? 1 : 0);
      @(negedge clk);
      check({tag, " pulse"}, int'(bus.result_valid), 0);
      check({tag, " idle"}, int'(bus.busy), 0);
      check({tag, " held"}, int'(bus.result_count), v.count);
   endtask

   initial begin
      int n, prev_cyc, seen_rv;
      int order[5];
      order = '{0, 1, 2, 3, 0};

      vecs[0] = '{rq: 0, word: 8'b1011_1011, pat: 4'b1011, len: 3'd4, ovl: 1'b1, count: 2};
      vecs[1] = '{rq: 2, word: 8'hFF,        pat: 4'b1111, len: 3'd4, ovl: 1'b1, count: 5};
      vecs[2] = '{rq: 2, word: 8'hFF,        pat: 4'b1111, len: 3'd4, ovl: 1'b0, count: 2};
      vecs[3] = '{rq: 1, word: 8'hFF,        pat: 4'b1111, len: 3'd0, ovl: 1'b1, count: 0};
      vecs[4] = '{rq: 3, word: 8'hFF,        pat: 4'b1111, len: 3'd7, ovl: 1'b1, count: 5};
      vecs[5] = '{rq: 1, word: 8'hAA,        pat: 4'b0101, len: 3'd4, ovl: 1'b1, count: 2};
      vecs[6] = '{rq: 0, word: 8'h00,        pat: 4'b0000, len: 3'd3, ovl: 1'b0, count: 2};
      vecs[7] = '{rq: 3, word: 8'h00,        pat: 4'b0000, len: 3'd3, ovl: 1'b1, count: 6};

      reset = 1'b0;
      bus.req = '0;
      bus.word_in = '0;
      cfg_pattern = '0;
      cfg_len = '0;
      cfg_overlap = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst ack", int'(bus.ack), 0);
      check("rst busy", int'(bus.busy), 0);
      check("rst valid", int'(bus.result_valid), 0);
      check("rst id", int'(bus.result_id), 0);
      check("rst hit", int'(bus.result_hit), 0);
      check("rst count", int'(bus.result_count), 0);
      #1 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle ack", int'(bus.ack), 0);
         check("idle busy", int'(bus.busy), 0);
      end

      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         run_word(vecs[i], $sformatf("vec%0d", i));
      end

      // Round robin with all requesters held high from a fresh pointer.
      do_reset();
      bus.req = 4'b1111;
      bus.word_in = {4{8'hF0}};
      cfg_pattern = 4'b1111;
      cfg_len = 3'd4;
      cfg_overlap = 1'b1;
      prev_cyc = 0;
      for (int g = 0; g < 5; g++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (bus.ack == '0 && n < 30);
         check($sformatf("rr ack%0d", g), int'(bus.ack), 1 << order[g]);
         if (g > 0) check($sformatf("rr spacing%0d", g), cyc - prev_cyc, WORD_W + 2);
         prev_cyc = cyc;
         n = 0;
         do begin @(negedge clk); n++; end while (!bus.result_valid && n < 30);
         check($sformatf("rr id%0d", g), int'(bus.result_id), order[g]);
         check($sformatf("rr count%0d", g), int'(bus.result_count), 1);
      end
      @(posedge clk); #1 bus.req = '0;
      repeat (WORD_W + 3) @(posedge clk);

      // Reset in the 4th SHIFT cycle aborts the word and rewinds the pointer.
      do_reset();
      bus.word_in = {4{8'hFF}};
      bus.req = 4'b0010;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.ack == '0 && n < 30);
      check("abort ack", int'(bus.ack), 2);
      @(posedge clk); #1 bus.req = '0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      seen_rv = 0;
      @(negedge clk);
      check("abort busy", int'(bus.busy), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.result_valid) seen_rv++;
      end
      check("abort no result", seen_rv, 0);
      @(posedge clk); #1 bus.req = 4'b1010;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.ack == '0 && n < 30);
      check("post-abort ack", int'(bus.ack), 2);
      @(posedge clk); #1 bus.req = '0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.result_valid && n < 30);
      check("post-abort id", int'(bus.result_id), 1);
      check("post-abort count", int'(bus.result_count), 5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
Shared serial pattern-detection engine with a round-robin scheduler in front of it. NREQ requesters each submit a WORD_W-bit word. The block grants one requester at a time and shifts the word MSB-first through a programmable bit-pattern matcher (pattern/length/overlap configurable). It then reports per-word match count and requester ID. It sits between producer blocks and the sequence-detector datapath, time-multiplexing a single detector among all of them.

Parameters:
NREQ, 4, number of requesters (>=2)
WORD_W, 8, bits per submitted word
PAT_W, 4, maximum pattern length in bits
(derived) IDW = $clog2(NREQ); LW = $clog2(PAT_W+1); CW = $clog2(WORD_W+1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  NREQ  per-requester request; held high with word stable until ack
word_in  input  NREQ*WORD_W  requester i word at bits [i*WORD_W +: WORD_W]
ack  output  NREQ  one-hot, one-cycle pulse; word of that requester sampled this edge
cfg_pattern  input  PAT_W  pattern; low cfg_len bits used, bit0 = most recent bit
cfg_len  input  LW  pattern length; 0 = detector disabled; >PAT_W clamped to PAT_W
cfg_overlap  input  1  1 = overlapping matches counted; 0 = history cleared after each match
busy  output  1  high in SHIFT and REPORT
result_valid  output  1  one-cycle pulse, word result available
result_id  output  IDW  requester index of reported word
result_hit  output  1  result_count != 0
result_count  output  CW  matches found in word

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, hist=0, bit_cnt=0, match_cnt=0. ack, busy, result_valid, result_id, result_hit, result_count all 0. Reset mid-word aborts: no result_valid, no ack.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE: if any req, grant first set req[k] scanning k = rr_ptr, rr_ptr+1, ... mod NREQ. ack[k]=1 combinationally in this cycle. On the edge: latch word_in[k], latch k as gnt_id, snapshot cfg_pattern/cfg_len(clamped)/cfg_overlap, clear hist/bit_cnt/match_cnt, go to SHIFT. No req: stay, ack=0.
- SHIFT: exactly WORD_W cycles; cycle j (0-based) consumes word bit WORD_W-1-j.
  - hist_n = {hist[PAT_W-2:0], bit}; seen_n = min(seen+1, PAT_W).
  - Match when len!=0, seen_n>=len, and hist_n[len-1:0]==pattern[len-1:0]. Then match_cnt++.
  - If cfg_overlap=0 on a match: hist and seen cleared instead of updated.
  - After the WORD_W-th bit, go to REPORT.
- REPORT: result_valid=1 for one cycle; result_id=gnt_id, result_count=match_cnt, result_hit=(match_cnt!=0). Results held registered until next REPORT. rr_ptr=(gnt_id+1) mod NREQ; go to IDLE.
- Latency: ack at cycle T -> result_valid at T+WORD_W+1. Back-to-back grant spacing = WORD_W+2 cycles.
- Config or req changes after ack do not affect the word in flight. req of the granted requester is ignored until next IDLE.
- match_cnt cannot overflow (max WORD_W fits in CW bits).
- Single requester alone is granted repeatedly regardless of rr_ptr.

Test Plan:
- Reset then idle: reset=0 for 2 cycles -> all outputs 0; release with req=0 -> ack stays 0, busy=0.
- req[0]=1, word 8'b1011_1011, pattern 4'b1011, len=4, overlap=1 -> ack[0] at T, result_valid at T+9, id=0, count=2, hit=1.
- req[2]=1, word 8'hFF, pattern 4'b1111, len=4: overlap=1 -> count=5; repeat with overlap=0 -> count=2.
- req=4'b1111 held, all words 8'hF0, pattern 4'b1111 len=4 -> acks ordered 0,1,2,3,0 spaced 10 cycles; each result count=1, id matches ack order.
- len=0, word 8'hFF -> count=0, hit=0. len=7 (clamped to 4), pattern 4'b1111, word 8'hFF, overlap=1 -> count=5.
- req[1]=1 accepted, reset pulsed low at 4th SHIFT cycle -> no result_valid. After release: state IDLE, rr_ptr=0; req[1] and req[3] both high -> ack[1] granted first.
